// File: rtl/pa_clk_en_gen.sv
// pa_clk_en_gen: divided bus-clock strobe generator on the always-on CPU clock.
// clk_en pulses once every (cur_ratio + 1) cycles. The strobe can be parked low
// with clk_en_halt. The divide ratio can change at runtime, but only on a strobe
// boundary.
// Build option: define PA_CLK_RATIO_CHG_EN to enable the runtime ratio-change
// handshake (ratio_req / ratio_ack / ratio_busy). Without it, the ratio is
// fixed at RST_RATIO.
module pa_clk_en_gen #(
    parameter int RATIO_W   = 3,
    parameter int RST_RATIO = 0
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    input  logic               clk_en_halt,
    input  logic               ratio_req,
    input  logic [RATIO_W-1:0] ratio_val,
    output logic               ratio_busy,
    output logic               ratio_ack,
    output logic [RATIO_W-1:0] cur_ratio,
    output logic               clk_en
);

    localparam logic [RATIO_W-1:0] RST_VAL = RATIO_W'(RST_RATIO);
    localparam logic [RATIO_W-1:0] ONE     = RATIO_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] cur_ratio_q, cur_ratio_d;
    logic               ratio_ack_q, ratio_ack_d;
    logic               req_en;
    logic               cnt_zero;

`ifdef PA_CLK_RATIO_CHG_EN
    logic [RATIO_W-1:0] nxt_ratio_q, nxt_ratio_d;

    assign req_en = ratio_req;
`else
    // Requests are ignored entirely when the ratio is fixed.
    logic unused_ratio_req;

    assign unused_ratio_req = ratio_req;
    assign req_en           = 1'b0;
`endif

    assign cnt_zero = (cnt_q == '0);

    // State, counter, ratio and ack registers with synchronous active-low reset.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_ratio_q <= RST_VAL;
            ratio_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_ratio_q <= cur_ratio_d;
            ratio_ack_q <= ratio_ack_d;
        end
    end

`ifdef PA_CLK_RATIO_CHG_EN
    // Holds a ratio captured mid-count until the current period completes.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            nxt_ratio_q <= RST_VAL;
        end else begin
            nxt_ratio_q <= nxt_ratio_d;
        end
    end
`endif

    // Next-state logic: period counting, ratio handoff on boundaries, halt park.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_ratio_d = cur_ratio_q;
        ratio_ack_d = 1'b0;
`ifdef PA_CLK_RATIO_CHG_EN
        nxt_ratio_d = nxt_ratio_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                if (cnt_zero) begin
                    // Strobe cycle: reload, optionally with a new ratio.
                    cnt_d = cur_ratio_q;
                    if (req_en) begin
                        cur_ratio_d = ratio_val;
                        cnt_d       = ratio_val;
                        ratio_ack_d = 1'b1;
                    end
                    if (clk_en_halt) begin
                        cnt_d   = '0;
                        state_d = S_HALT;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                    if (req_en) begin
`ifdef PA_CLK_RATIO_CHG_EN
                        nxt_ratio_d = ratio_val;
`endif
                        state_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (cnt_zero) begin
`ifdef PA_CLK_RATIO_CHG_EN
                    cur_ratio_d = nxt_ratio_q;
                    cnt_d       = nxt_ratio_q;
                    ratio_ack_d = 1'b1;
`else
                    cnt_d       = cur_ratio_q;
`endif
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_HALT: begin
                // Parked with the counter at zero so the exit strobe is immediate.
                cnt_d = '0;
                if (req_en) begin
                    cur_ratio_d = ratio_val;
                    ratio_ack_d = 1'b1;
                end
                if (!clk_en_halt) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from flops only.
    always_comb begin
        clk_en = ((state_q == S_RUN) || (state_q == S_PEND)) && cnt_zero;
`ifdef PA_CLK_RATIO_CHG_EN
        ratio_busy = (state_q == S_IDLE) || (state_q == S_PEND);
`else
        ratio_busy = (state_q == S_IDLE);
`endif
    end

    assign ratio_ack = ratio_ack_q;
    assign cur_ratio = cur_ratio_q;

endmodule

// File: tb/tb_pa_clk_en_gen.sv
// Testbench for pa_clk_en_gen. It uses directed scenarios followed by random
// traffic. A time-based reference model predicts every output each cycle.
module tb_pa_clk_en_gen;

    localparam int RW    = 3;
    localparam int RST_R = 2;
`ifdef PA_CLK_RATIO_CHG_EN
    localparam bit CHG = 1'b1;
`else
    localparam bit CHG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstb;
    logic          halt;
    logic          req;
    logic [RW-1:0] val;
    logic          busy;
    logic          ack;
    logic [RW-1:0] cur;
    logic          en;

    always #5 clk = ~clk;

    pa_clk_en_gen #(
        .RATIO_W  (RW),
        .RST_RATIO(RST_R)
    ) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (rstb),
        .clk_en_halt   (halt),
        .ratio_req     (req),
        .ratio_val     (val),
        .ratio_busy    (busy),
        .ratio_ack     (ack),
        .cur_ratio     (cur),
        .clk_en        (en)
    );

    int t;
    int npass;
    int ntotal;

    // Reference model: absolute time of the next strobe, rather than a countdown.
    bit            m_run;
    bit            m_halt;
    bit            m_pend;
    bit            m_ack;
    logic [RW-1:0] m_cur;
    logic [RW-1:0] m_pval;
    int            m_next;

    logic          obs_en;
    logic          obs_ack;
    logic          obs_busy;
    logic [RW-1:0] obs_cur;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", name, t, got, exp);
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_halt = 1'b0;
        m_pend = 1'b0;
        m_ack  = 1'b0;
        m_cur  = RW'(RST_R);
        m_pval = RW'(RST_R);
        m_next = 0;
    endtask

    task automatic model_update(input logic h, input logic r, input logic [RW-1:0] v,
                                input logic rb);
        bit ack_n;
        bit acc;
        ack_n = 1'b0;
        if (!rb) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            m_run  = 1'b1;
            m_next = t + 1;
        end else if (m_halt) begin
            if (CHG && r) begin
                m_cur = v;
                ack_n = 1'b1;
            end
            if (!h) begin
                m_halt = 1'b0;
                m_next = t + 1;
            end
        end else begin
            acc = CHG && r && !m_pend;
            if (t == m_next) begin
                if (m_pend) begin
                    m_cur  = m_pval;
                    m_pend = 1'b0;
                    ack_n  = 1'b1;
                end else begin
                    if (acc) begin
                        m_cur = v;
                        ack_n = 1'b1;
                    end
                    if (h) m_halt = 1'b1;
                end
                m_next = t + int'(m_cur) + 1;
            end else if (acc) begin
                m_pend = 1'b1;
                m_pval = v;
            end
        end
        m_ack = ack_n;
    endtask

    task automatic check_outputs();
        logic exp_en;
        logic exp_busy;
        exp_en   = m_run && !m_halt && (t == m_next);
        exp_busy = CHG ? (!m_run || m_pend) : !m_run;
        obs_en   = en;
        obs_ack  = ack;
        obs_busy = busy;
        obs_cur  = cur;
        chk("clk_en", 8'(en), 8'(exp_en));
        chk("ratio_busy", 8'(busy), 8'(exp_busy));
        chk("ratio_ack", 8'(ack), 8'(m_ack));
        chk("cur_ratio", 8'(cur), 8'(m_cur));
    endtask

    // One cycle: check outputs at negedge, drive inputs, advance the model at posedge.
    task automatic step(input logic h, input logic r, input logic [RW-1:0] v, input logic rb);
        @(negedge clk);
        check_outputs();
        halt = h;
        req  = r;
        val  = v;
        rstb = rb;
        @(posedge clk);
        model_update(h, r, v, rb);
        t++;
    endtask

    task automatic idle_until(input int target);
        while (t < target) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          hr;
        logic          rr;
        logic          rbr;
        logic [RW-1:0] vr;
        npass  = 0;
        ntotal = 0;
        t      = 0;
        rstb   = 1'b0;
        halt   = 1'b0;
        req    = 1'b0;
        val    = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, then release; strobes every 3 cycles starting 2 cycles in.
        step(1'b0, 1'b0, '0, 1'b0);
        chk("rst_en", 8'(obs_en), 8'd0);
        chk("rst_busy", 8'(obs_busy), 8'd1);
        chk("rst_cur", 8'(obs_cur), 8'(RST_R));
        step(1'b0, 1'b0, '0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            chk("rst_pattern", 8'(obs_en), 8'(((k - 1) % 3) == 0));
        end

        if (CHG) begin
            // Mid-count change: ratio 3, request ratio 1 one cycle after a strobe.
            idle_until(m_next);
            step(1'b0, 1'b1, 3'd3, 1'b1);
            idle_until(m_next + 1);
            step(1'b0, 1'b1, 3'd1, 1'b1);
            step(1'b0, 1'b0, '0, 1'b1);
            chk("pend_busy", 8'(obs_busy), 8'd1);
            step(1'b0, 1'b0, '0, 1'b1);
            step(1'b0, 1'b0, '0, 1'b1);
            chk("pend_strobe", 8'(obs_en), 8'd1);
            step(1'b0, 1'b0, '0, 1'b1);
            chk("pend_ack", 8'(obs_ack), 8'd1);
            chk("pend_cur", 8'(obs_cur), 8'd1);
            idle_until(t + 6);

            // Boundary change: ratio 2, then ratio 0 requested in a strobe cycle.
            idle_until(m_next);
            step(1'b0, 1'b1, 3'd2, 1'b1);
            idle_until(m_next);
            step(1'b0, 1'b1, 3'd0, 1'b1);
            step(1'b0, 1'b0, '0, 1'b1);
            chk("bnd_ack", 8'(obs_ack), 8'd1);
            chk("bnd_en0", 8'(obs_en), 8'd1);
            step(1'b0, 1'b0, '0, 1'b1);
            chk("bnd_en1", 8'(obs_en), 8'd1);
            chk("bnd_ack_once", 8'(obs_ack), 8'd0);

            // Halt and resume at ratio 1.
            step(1'b0, 1'b1, 3'd1, 1'b1);
            idle_until(m_next + 1);
            repeat (4) step(1'b1, 1'b0, '0, 1'b1);
            chk("halt_low", 8'(obs_en), 8'd0);
            step(1'b0, 1'b0, '0, 1'b1);
            step(1'b0, 1'b0, '0, 1'b1);
            chk("halt_exit", 8'(obs_en), 8'd1);

            // Request during PEND is dropped; only one ack follows.
            idle_until(m_next);
            step(1'b0, 1'b1, 3'd3, 1'b1);
            idle_until(m_next + 1);
            step(1'b0, 1'b1, 3'd1, 1'b1);
            step(1'b0, 1'b1, 3'd5, 1'b1);
            idle_until(t + 10);
            chk("drop_cur", 8'(obs_cur), 8'd1);

            // Reset during PEND: no ack, strobe off, ratio reverts.
            idle_until(m_next + 1);
            step(1'b0, 1'b1, 3'd6, 1'b1);
            step(1'b0, 1'b0, '0, 1'b0);
            step(1'b0, 1'b0, '0, 1'b0);
            chk("abort_ack", 8'(obs_ack), 8'd0);
            chk("abort_en", 8'(obs_en), 8'd0);
            chk("abort_cur", 8'(obs_cur), 8'(RST_R));
            step(1'b0, 1'b0, '0, 1'b1);
        end else begin
            // Fixed ratio: requests change nothing and are never acknowledged.
            step(1'b0, 1'b1, 3'd5, 1'b1);
            step(1'b0, 1'b1, 3'd0, 1'b1);
            step(1'b0, 1'b0, '0, 1'b1);
            chk("fix_ack", 8'(obs_ack), 8'd0);
            chk("fix_cur", 8'(obs_cur), 8'(RST_R));
            idle_until(m_next + 1);
            repeat (4) step(1'b1, 1'b1, 3'd7, 1'b1);
            chk("fix_halt_low", 8'(obs_en), 8'd0);
            step(1'b0, 1'b0, '0, 1'b1);
            step(1'b0, 1'b0, '0, 1'b1);
            chk("fix_halt_exit", 8'(obs_en), 8'd1);
        end

        // Random traffic against the model.
        hr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15, 0) == 0) hr = ~hr;
            rr  = ($urandom_range(3, 0) == 0);
            vr  = RW'($urandom_range(7, 0));
            rbr = ($urandom_range(199, 0) != 0);
            step(hr, rr, vr, rbr);
        end
        step(1'b0, 1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/pa_clk_en_gen.md
# pa_clk_en_gen

Generates the `clk_en` strobe consumed by the clock top's `clk_en_f` register. The strobe marks the rising edges of a divided bus clock on the always-on CPU clock. The divide ratio can change at runtime through a pulse/ack handshake, and the change takes effect only on a strobe boundary. A halt input parks the strobe low for low-power entry. The block sits beside the clock top, upstream of all bus-side clock-enable consumers.

## Interface
- `RATIO_W`, default 3: width of the ratio field. Divide factor = ratio + 1.
- `RST_RATIO`, default 0: ratio loaded at reset.
- `forever_cpuclk`, in, 1: always-on CPU clock; the only clock.
- `cpurst_b`, in, 1: reset. Synchronous, active-low.
- `clk_en_halt`, in, 1: level; request to park the strobe low.
- `ratio_req`, in, 1: single-cycle pulse requesting a ratio change.
- `ratio_val`, in, `RATIO_W`: new ratio, sampled with `ratio_req`.
- `ratio_busy`, out, 1: high while a `ratio_req` would be ignored.
- `ratio_ack`, out, 1: one-cycle pulse; the new ratio is in effect.
- `cur_ratio`, out, `RATIO_W`: ratio currently in effect.
- `clk_en`, out, 1: divided-clock strobe.

## Operation
- **State registers:** `state` ∈ {IDLE, RUN, PEND, HALT}, `cnt[RATIO_W]`, `cur_ratio`, `nxt_ratio`, `ratio_ack`.
- **Output decode:** `clk_en = (state==RUN || state==PEND) && cnt==0`. This is decoded from flops only.
- **Busy:** `ratio_busy = (state==IDLE || state==PEND)`.
- **IDLE:** `clk_en` is 0. Next state is RUN with `cnt=0`.
- **RUN and PEND counting:** when `cnt==0`, load `cnt<=cur_ratio`; otherwise decrement `cnt`.
- **RUN, request mid-count:** `ratio_req` with `cnt!=0` latches `nxt_ratio<=ratio_val` and moves to PEND.
- **RUN, request at boundary:** `ratio_req` with `cnt==0` has these effects:
  - The current strobe is still issued.
  - `cur_ratio<=ratio_val` and `cnt<=ratio_val`.
  - `ratio_ack` pulses the next cycle.
  - State stays RUN.
- **PEND:** at `cnt==0` the strobe is issued, then:
  - `cur_ratio<=nxt_ratio` and `cnt<=nxt_ratio`.
  - `ratio_ack` pulses the next cycle.
  - State returns to RUN.
- **Halt entry:** only from RUN, at a boundary. `clk_en_halt` high with `cnt==0` issues this final strobe, sets `cnt<=0` and moves to HALT.
- **Halt and request together:** if `clk_en_halt` and `ratio_req` arrive together at a boundary in RUN, both are taken. The ratio is applied, the ack pulses, and the state moves to HALT with `cnt=0`.
- **HALT behaviour:**
  - `clk_en` is 0 and `cnt` is held at 0.
  - `ratio_req` applies immediately: `cur_ratio<=ratio_val`, with an ack the next cycle.
  - When `clk_en_halt` goes low, the state moves to RUN.
- **Halt in PEND:** ignored until PEND completes back to RUN.
- **Ratio 0:** `clk_en` is continuously high in RUN.
- **Ignored requests:** `ratio_req` is ignored while `ratio_busy`, with no ack. The requester must retry.
- **Arithmetic:** `cnt` decrements only from nonzero values, so it never wraps. All arithmetic is unsigned `RATIO_W`.

## Timing
- **Reset values:** on a `forever_cpuclk` edge with `cpurst_b==0`:
  - `state=IDLE`, `cnt=0`, `cur_ratio=nxt_ratio=RST_RATIO`.
  - Outputs: `clk_en=0`, `ratio_ack=0`, `ratio_busy=1`, `cur_ratio=RST_RATIO`.
- **Reset mid-operation:** aborts any PEND. No ack is issued, and the ratio reverts to `RST_RATIO`.
- **First strobe:** in the second cycle after `cpurst_b` rises (IDLE→RUN).
- **Strobe period:** `clk_en` is high for one cycle in every `cur_ratio+1` cycles.
- **Ratio change latency:** the old-ratio period always completes, so there are no short or long strobe gaps. `ratio_ack` is 1 cycle after the new ratio loads. The first new-ratio strobe is `new+1` cycles after the last old-ratio strobe.
- **Halt exit:** the first strobe comes 1 cycle after `clk_en_halt` is sampled low in HALT.
- All outputs except `clk_en` and `ratio_busy` are direct flop outputs. Those two are decoded from flops only.

## Configuration
- Macro `PA_CLK_RATIO_CHG_EN`.
- **Defined:** runtime ratio change as described above.
- **Undefined:**
  - `ratio_req` and `ratio_val` are ignored.
  - `ratio_ack` is tied 0, and `ratio_busy` is 1 only in IDLE.
  - PEND is unreachable, and `nxt_ratio` is not implemented.
  - `cur_ratio` is fixed at `RST_RATIO`.
  - Halt and strobe behaviour are unchanged.

## Test plan
- **Reset:** `RST_RATIO=2`, release reset. Expect `clk_en` high in cycles 2, 5, 8… after release, and `cur_ratio=2`.
- **Mid-count change:** ratio 3. Pulse `ratio_req` with `ratio_val=1` one cycle after a strobe. Expect PEND, the next strobe 3 cycles later, `ratio_ack` one cycle after that, then strobes every 2 cycles.
- **Boundary change:** ratio 2. Pulse `ratio_req` with `ratio_val=0` in a strobe cycle. Expect `ratio_ack` the next cycle and `clk_en` continuously high from the cycle after the strobe.
- **Halt and resume:** ratio 1. Raise `clk_en_halt` mid-period. Expect one more strobe, then `clk_en` 0. Lower halt and expect a strobe 1 cycle later.
- **Busy drop and reset abort:** `ratio_req` during PEND is dropped with no second ack. Assert `cpurst_b=0` during PEND; expect no ack, `clk_en=0`, `cur_ratio=RST_RATIO`.
- **Macro undefined:** `ratio_req` pulses produce no ack and `cur_ratio` is unchanged.
